// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked sequential ALU.
//   alu_op_e    - 4-bit opcode encoding
//   alu_flags_t - packed status flags {z, n, c, v}
//   alu_state_e - control FSM states (BUSY only used when ALU_MUL_EN is defined)
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operation port and result port of alu_seq.
//   master: issues operations (in_valid/in0/in1/op) and consumes results (out_ready)
//   slave : the ALU (in_ready, out_valid, out, flag_z/n/c/v)
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in0;
  logic [N-1:0]  in1;
  alu_op_e       op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;

  modport master (
    output in_valid, in0, in1, op, out_ready,
    input  in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, in0, in1, op, out_ready,
    output in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: N-cycle shift-add unsigned multiplier.
//   clk, rst_n - clock, async active-low reset
//   start      - load operands a, b (performs the first add/shift step)
//   done       - one-cycle pulse when product holds the final value
//   product    - 2N-bit product, held until the next start
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = 2 * N;

  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;

  // Step 1 happens on the start edge so the product is final N-1 edges later;
  // done then lets the top load the result on the N-th edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {N'(0), a} : '0;
      mcand  <= {N'(0), a} << 1;
      mplier <= b >> 1;
      cnt    <= CW'(N - 1);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      done   <= (cnt == CW'(1));
    end else begin
      done   <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result and status flags.
//   clk, rst_n - clock, async active-low reset
//   bus        - alu_seq_if.slave: in_valid/in_ready/in0/in1/op operation port,
//                out_valid/out_ready/out/flag_z/n/c/v result port
// Build option: define ALU_MUL_EN to execute op MUL as an N-cycle shift-add
// multiply through the BUSY state; otherwise MUL behaves as an unknown opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [SW-1:0] sh;
  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [N-1:0]  res_c;
  alu_flags_t    flg_c;

  logic [N-1:0]  out_q, out_n;
  alu_flags_t    flags_q, flags_n;
  logic          valid_q, valid_n;
  logic          in_ready;
  logic          fire_in;

  assign a  = bus.in0;
  assign b  = bus.in1;
  assign sh = b[SW-1:0];

  // Single-cycle datapath: result and flags for the offered operation.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res_c = a;
    flg_c = '0;
    case (bus.op)
      OP_ADD: begin
        res_c   = sum[N-1:0];
        flg_c.c = sum[N];
        flg_c.v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res_c   = diff[N-1:0];
        flg_c.c = diff[N];
        flg_c.v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLL:  res_c = a << sh;
      OP_SRL:  res_c = a >> sh;
      OP_SRA:  res_c = N'($signed(a) >>> sh);
      OP_SLT:  res_c = N'($signed(a) < $signed(b));
      OP_SLTU: res_c = N'(a < b);
      default: res_c = a;
    endcase
    flg_c.z = (res_c == '0);
    flg_c.n = res_c[N-1];
  end

`ifdef ALU_MUL_EN
  alu_state_e     state_q, state_n;
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] product;

  assign in_ready = (state_q == ST_IDLE) && (!valid_q || bus.out_ready);

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );
`else
  assign in_ready = !valid_q || bus.out_ready;
`endif

  assign fire_in = bus.in_valid && in_ready;

  // Next-state: drain clears valid; an accept (or multiply completion) reloads it.
  always_comb begin
    out_n   = out_q;
    flags_n = flags_q;
    valid_n = valid_q && !bus.out_ready;
`ifdef ALU_MUL_EN
    state_n   = state_q;
    mul_start = 1'b0;
    if (state_q == ST_IDLE) begin
      if (fire_in) begin
        if (bus.op == OP_MUL) begin
          state_n   = ST_BUSY;
          mul_start = 1'b1;
        end else begin
          out_n   = res_c;
          flags_n = flg_c;
          valid_n = 1'b1;
        end
      end
    end else if (mul_done) begin
      state_n   = ST_IDLE;
      out_n     = product[N-1:0];
      flags_n.z = (product[N-1:0] == '0);
      flags_n.n = product[N-1];
      flags_n.c = |product[2*N-1:N];
      flags_n.v = 1'b0;
      valid_n   = 1'b1;
    end
`else
    if (fire_in) begin
      out_n   = res_c;
      flags_n = flg_c;
      valid_n = 1'b1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q <= ST_IDLE;
`endif
    end else begin
      out_q   <= out_n;
      flags_q <= flags_n;
      valid_q <= valid_n;
`ifdef ALU_MUL_EN
      state_q <= state_n;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_v    = flags_q.v;

endmodule
